// File: rtl/qa_sequencer.sv
// qa_sequencer: control FSM for the Pikachu quick-attack animation; drives the quick_attack enables
// and gates its pixel stream to the VGA adapter. Define QA_SEQ_ERASE_EN to add a per-frame erase pass.
`timescale 1ns/1ps
module qa_sequencer #(
  parameter logic [2:0] ERASE_COLOUR = 3'b000
) (
  input  logic       clock,
  input  logic       reset_all,
  input  logic       start,
  input  logic       done_pikachu,
  input  logic       done_animate,
  input  logic       done_quick_attack,
  input  logic [8:0] p_qa_x,
  input  logic [7:0] p_qa_y,
  input  logic [2:0] p_qa_colour,
  output logic       enable_animate,
  output logic       enable_p_qa,
  output logic       enable_draw_pika,
  output logic [8:0] vga_x,
  output logic [7:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       attack_done,
  output logic [5:0] frames_drawn
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRAW  = 3'd1,
    ST_WAIT  = 3'd2,
`ifdef QA_SEQ_ERASE_EN
    ST_ERASE = 3'd3,
`endif
    ST_MOVE  = 3'd4,
    ST_FINAL = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  state_t     r_state;
  logic       r_fin_flag;
  logic [5:0] r_frames;

  // Sequencer state, frame counter and sticky end-of-attack flag.
  always_ff @(posedge clock or negedge reset_all) begin
    if (!reset_all) begin
      r_state    <= ST_IDLE;
      r_fin_flag <= 1'b0;
      r_frames   <= 6'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state  <= ST_DRAW;
            r_frames <= 6'd0;
          end
        end
        ST_DRAW: begin
          if (done_pikachu) r_state <= ST_WAIT;
        end
        ST_WAIT: begin
`ifdef QA_SEQ_ERASE_EN
          if (done_animate) r_state <= ST_ERASE;
`else
          if (done_animate) r_state <= ST_MOVE;
`endif
        end
`ifdef QA_SEQ_ERASE_EN
        ST_ERASE: begin
          if (done_pikachu) r_state <= ST_MOVE;
        end
`endif
        ST_MOVE: begin
          if (r_fin_flag) begin
            r_state <= ST_FINAL;
          end else begin
            r_state <= ST_DRAW;
            if (r_frames != 6'd63) r_frames <= r_frames + 6'd1;
          end
        end
        ST_FINAL: begin
          if (done_pikachu) r_state <= ST_DONE;
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase

      // Flag is captured in every active state, including on the cycle of a transition.
      if (r_state == ST_IDLE) begin
        if (start) r_fin_flag <= 1'b0;
      end else if (done_quick_attack) begin
        r_fin_flag <= 1'b1;
      end
    end
  end

  // State decode for the drawer enables and the VGA pixel gate.
  always_comb begin
    enable_animate   = 1'b0;
    enable_p_qa      = 1'b0;
    enable_draw_pika = 1'b0;
    vga_plot         = 1'b0;
    vga_colour       = 3'b000;
    busy             = 1'b1;
    attack_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
      end
      ST_DRAW, ST_FINAL: begin
        enable_animate   = 1'b1;
        enable_draw_pika = 1'b1;
        vga_plot         = 1'b1;
        vga_colour       = p_qa_colour;
      end
      ST_WAIT: begin
        enable_animate = 1'b1;
      end
`ifdef QA_SEQ_ERASE_EN
      ST_ERASE: begin
        enable_animate   = 1'b1;
        enable_draw_pika = 1'b1;
        vga_plot         = 1'b1;
        vga_colour       = ERASE_COLOUR;
      end
`endif
      ST_MOVE: begin
        enable_animate = 1'b1;
        enable_p_qa    = ~r_fin_flag;
      end
      ST_DONE: begin
        attack_done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign vga_x        = p_qa_x;
  assign vga_y        = p_qa_y;
  assign frames_drawn = r_frames;

`ifndef QA_SEQ_ERASE_EN
  logic w_unused_erase_colour;
  assign w_unused_erase_colour = ^ERASE_COLOUR;
`endif

endmodule

// File: doc/qa_sequencer.md
# qa_sequencer

Control sequencer for the Pikachu quick-attack animation. It sits directly upstream of `quick_attack` and drives its `enable_animate`, `enable_p_qa` and `enable_draw_pika` inputs from that block's `done_pikachu`, `done_animate` and `done_quick_attack` returns. It also sits in the pixel path between `quick_attack` and the VGA adapter, where it gates the plot strobe and forces black during erase passes.

## Interface
Parameters:
- `ERASE_COLOUR`, default 3'b000: colour driven on `vga_colour` during erase passes.

Ports (one clock; `reset_all` is asynchronous, active-low):
- `clock`  in  1  system clock.
- `reset_all`  in  1  async active-low reset for the sequencer; also routed unchanged to `quick_attack`.
- `start`  in  1  one-cycle request to run one quick attack; sampled only in IDLE.
- `done_pikachu`  in  1  sprite raster pass complete.
- `done_animate`  in  1  frame-tick pulse.
- `done_quick_attack`  in  1  one-cycle pulse marking the end of the 50-frame attack.
- `p_qa_x`, `p_qa_y`, `p_qa_colour`  in  9/8/3  pixel stream from `quick_attack`.
- `enable_animate`, `enable_p_qa`, `enable_draw_pika`  out  1 each  enables to `quick_attack`.
- `vga_x`, `vga_y`, `vga_colour`, `vga_plot`  out  9/8/3/1  pixel to the VGA adapter.
- `busy`  out  1  high from acceptance of `start` until the end of the DONE state.
- `attack_done`  out  1  one-cycle completion pulse.
- `frames_drawn`  out  6  count of MOVE steps in the current attack; saturates at 63.

## Operation
- States: IDLE, DRAW, WAIT, ERASE, MOVE, FINAL, DONE.
- IDLE: all enables low. `start` moves to DRAW, clears `frames_drawn`, and clears `fin_flag`.
- DRAW: `enable_draw_pika`=1, `vga_plot`=1, `vga_colour`=`p_qa_colour`. `done_pikachu` moves to WAIT.
- WAIT: enables to the drawer low. A `done_animate` pulse moves to ERASE, or to MOVE when erase is compiled out.
- ERASE: `enable_draw_pika`=1, `vga_plot`=1, `vga_colour`=`ERASE_COLOUR`. `done_pikachu` moves to MOVE.
- MOVE (exactly 1 cycle):
  - If `fin_flag`=0: `enable_p_qa`=1, `frames_drawn`+1, go to DRAW.
  - If `fin_flag`=1: `enable_p_qa`=0, go to FINAL.
- FINAL: same outputs as DRAW. `done_pikachu` moves to DONE.
- DONE (1 cycle): `attack_done`=1, then IDLE.
- `enable_animate`=1 in every state except IDLE and DONE.
- `fin_flag` is sticky:
  - Set by `done_quick_attack` in any non-IDLE state.
  - Cleared on `start` acceptance and on reset.
- `vga_x`/`vga_y` are passthroughs of `p_qa_x`/`p_qa_y`. `vga_plot`=0 outside DRAW, ERASE and FINAL.
- `enable_draw_pika` is low for at least one cycle between consecutive passes (via WAIT or MOVE), so the drawer rearms.

## Timing
- Reset (async assert, synchronous release): state IDLE; all outputs 0; `frames_drawn`=0; `fin_flag`=0.
- `start` to `enable_draw_pika` high: 1 cycle (registered state).
- `done_pikachu` to `enable_draw_pika` low: 1 cycle.
- `done_animate` arriving in DRAW, ERASE, MOVE or FINAL is ignored; the sequencer waits for the next tick in WAIT.
- `done_quick_attack` coincident with any state transition: the flag is still captured.
- `start` while `busy`: ignored.
- `reset_all` low mid-attack: immediate return to IDLE, with outputs as listed for reset. `attack_done` does not pulse.
- Outputs that depend on state are combinational decodes of the registered state. `attack_done` is high for exactly one cycle.

## Configuration
- `QA_SEQ_ERASE_EN`:
  - Defined: ERASE state present, and each frame erases the old sprite before MOVE.
  - Undefined: ERASE is removed, WAIT goes directly to MOVE, and the sprite leaves a trail. `ERASE_COLOUR` is unused.

## Test plan
- Reset low at cycle 5 with `start` held high → all outputs 0, state IDLE; no enable rises until release and a fresh `start`.
- `start` pulse; `done_pikachu` 20 cycles later → `enable_draw_pika` high at cycle +1, low one cycle after `done_pikachu`; `vga_plot` mirrors it.
- Full attack: 50 `done_animate` ticks, `done_quick_attack` one cycle after the 50th → `enable_p_qa` pulses 50 times, each exactly 1 cycle; `frames_drawn`=50; FINAL pass; single `attack_done`; `busy` falls.
- Erase build: during ERASE with `p_qa_colour`=3'b110 → `vga_colour`=3'b000. Non-erase build → WAIT goes directly to MOVE and no ERASE cycles occur.
- `done_animate` during DRAW and `start` during WAIT → both ignored; state still waits for the next tick in WAIT.
- `reset_all` low for 1 cycle in MOVE → IDLE next edge, `enable_p_qa`=0, `attack_done` never asserts.
